// File: rtl/hk_pkg.sv
// rtl/hk_pkg.sv - shared constants, state encoding and frame-length helper for the HK frame packer
package hk_pkg;

  localparam logic [15:0] HK_SYNC_DEFAULT = 16'hEB90;
  localparam int          HK_WORD_W       = 10;

  typedef logic [2:0] hk_state_t;

  localparam hk_state_t HK_IDLE = 3'd0;
  localparam hk_state_t HK_SYNC = 3'd1;
  localparam hk_state_t HK_SEQ  = 3'd2;
  localparam hk_state_t HK_DATA = 3'd3;
  localparam hk_state_t HK_CSUM = 3'd4;

  function automatic int hk_frame_len(input int num_words);
    return 2 * num_words + 4;
  endfunction

endpackage

// File: rtl/hk_frame_packer.sv
// rtl/hk_frame_packer.sv - serialises a housekeeping word snapshot into a sync/seq/data/checksum byte frame
module hk_frame_packer
  import hk_pkg::*;
#(
  parameter logic [15:0] SYNC_WORD = HK_SYNC_DEFAULT,
  parameter int          NUM_WORDS = 10
) (
  input  logic                           clk50,
  input  logic                           rst_n,
  input  logic                           hk_tick,
  input  logic [HK_WORD_W*NUM_WORDS-1:0] hk_words,
  input  logic                           tx_ready,
  output logic [7:0]                     tx_data,
  output logic                           tx_valid,
  output logic                           busy,
  output logic                           frame_done,
  output logic [7:0]                     drop_cnt
);

  // Byte index spans 0..2*NUM_WORDS-1; its upper bits select the word, bit 0 the byte half.
  localparam int WIDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int IDX_W  = WIDX_W + 1;
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(2 * NUM_WORDS - 1);

  hk_state_t                      state;
  logic [IDX_W-1:0]               byte_idx;
  logic [HK_WORD_W*NUM_WORDS-1:0] snap;
  logic [7:0]                     seq;
  logic [7:0]                     csum;
  logic [HK_WORD_W-1:0]           words [NUM_WORDS];
  logic [HK_WORD_W-1:0]           cur_word;
  logic                           xfer;

  for (genvar k = 0; k < NUM_WORDS; k++) begin : g_word
    assign words[k] = snap[k*HK_WORD_W +: HK_WORD_W];
  end

  assign cur_word = words[byte_idx[IDX_W-1:1]];
  assign tx_valid = (state != HK_IDLE);
  assign busy     = (state != HK_IDLE);
  assign xfer     = tx_valid && tx_ready;

  always_comb begin
    tx_data = 8'h00;
    case (state)
      HK_SYNC: tx_data = byte_idx[0] ? SYNC_WORD[7:0] : SYNC_WORD[15:8];
      HK_SEQ:  tx_data = seq;
      HK_DATA: tx_data = byte_idx[0] ? cur_word[7:0] : {6'b0, cur_word[9:8]};
      HK_CSUM: tx_data = csum;
      default: tx_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HK_IDLE;
      byte_idx   <= '0;
      snap       <= '0;
      seq        <= 8'h00;
      csum       <= 8'h00;
      frame_done <= 1'b0;
      drop_cnt   <= 8'h00;
    end else begin
      frame_done <= 1'b0;
      // A tick landing on the checksum transfer edge is still counted as a drop.
      if (hk_tick && (state != HK_IDLE) && (drop_cnt != 8'hFF))
        drop_cnt <= drop_cnt + 8'd1;
      case (state)
        HK_IDLE: begin
          if (hk_tick) begin
            snap     <= hk_words;
            csum     <= 8'h00;
            byte_idx <= '0;
            state    <= HK_SYNC;
          end
        end
        HK_SYNC: begin
          if (xfer) begin
            if (byte_idx[0]) begin
              byte_idx <= '0;
              state    <= HK_SEQ;
            end else begin
              byte_idx <= byte_idx + 1'b1;
            end
          end
        end
        HK_SEQ: begin
          if (xfer) begin
            csum     <= csum + seq;
            byte_idx <= '0;
            state    <= HK_DATA;
          end
        end
        HK_DATA: begin
          if (xfer) begin
            csum <= csum + tx_data;
            if (byte_idx == LAST_DATA) begin
              byte_idx <= '0;
              state    <= HK_CSUM;
            end else begin
              byte_idx <= byte_idx + 1'b1;
            end
          end
        end
        HK_CSUM: begin
          if (xfer) begin
            frame_done <= 1'b1;
            seq        <= seq + 8'd1;
            state      <= HK_IDLE;
          end
        end
        default: state <= HK_IDLE;
      endcase
    end
  end

endmodule
